// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester's view of the data-memory arbiter: request payload travelling
// from the requester, grant and registered response travelling back.
//
//   req        request valid, held with stable payload until granted
//   we         1 = store, 0 = load
//   addr_mode  0 = word, 1 = byte
//   addr       byte address
//   wdata      store data (byte store uses [7:0])
//   gnt        request accepted this cycle (combinational)
//   rvalid     response valid, one-cycle pulse the cycle after gnt
//   rdata      load data, 0 for stores and faults
//   err        response is a fault, qualified by rvalid
//
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic                  addr_mode;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, we, addr_mode, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr_mode, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Round-robin arbiter and access sequencer sharing one single-port,
// byte-addressed data memory between requester 0 (load/store unit) and
// requester 1 (loader/debug port). One access per cycle; the memory is driven
// combinationally in the grant cycle and the response is registered and
// returned to the granted requester in the following cycle. Misaligned word
// accesses and out-of-range addresses are answered with err and never reach
// the memory.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   r0, r1         requester interfaces (slave modport)
//   mem_a          memory byte address
//   mem_wd         memory write data
//   mem_addr_mode  memory mode, 0 = word, 1 = byte
//   mem_we         memory write enable
//   mem_rd         memory combinational read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         r0,
    dmem_arbiter_if.slave         r1,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_addr_mode,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    // Highest word-aligned address whose four bytes all lie inside memory.
    localparam logic [ADDR_BITS-1:0] LAST_WORD = {{(ADDR_BITS-2){1'b1}}, 2'b00};

    // Registered state
    logic                  last_q,   last_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  err0_q,   err0_d;
    logic                  err1_q,   err1_d;

    // Grant-cycle combinational signals
    logic                  gnt0;
    logic                  gnt1;
    logic                  any_gnt;
    logic                  g_we;
    logic                  g_mode;
    logic [DATA_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic                  misaligned;
    logic                  high_bits;
    logic                  word_oor;
    logic                  fault;
    logic                  go;
    logic [DATA_WIDTH-1:0] resp_data;

    // Arbitration: a lone request wins; under contention the requester that
    // was not granted last time wins. Nothing is granted during reset so a
    // held request is simply arbitrated in the first cycle after reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (r0.req && (!r1.req || last_q)) begin
                gnt0 = 1'b1;
            end else if (r1.req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;

    always_comb begin
        g_we    = r0.we;
        g_mode  = r0.addr_mode;
        g_addr  = r0.addr;
        g_wdata = r0.wdata;
        if (gnt1) begin
            g_we    = r1.we;
            g_mode  = r1.addr_mode;
            g_addr  = r1.addr;
            g_wdata = r1.wdata;
        end
    end

    // Fault detection on the selected payload. For an aligned word the
    // word_oor term can only trip if ADDR_BITS is changed in a way that
    // leaves a partial word at the top; it is kept so the check stays exact.
    always_comb begin
        misaligned = !g_mode && (g_addr[1:0] != 2'b00);
        high_bits  = (g_addr >> ADDR_BITS) != '0;
        word_oor   = !g_mode && (g_addr[ADDR_BITS-1:0] > LAST_WORD);
        fault      = misaligned || high_bits || word_oor;
        go         = any_gnt && !fault;
    end

    // Memory port: driven only for an accepted, non-faulting access.
    always_comb begin
        mem_a         = '0;
        mem_wd        = '0;
        mem_addr_mode = 1'b0;
        mem_we        = 1'b0;
        if (go) begin
            mem_a         = g_addr;
            mem_wd        = g_wdata;
            mem_addr_mode = g_mode;
            mem_we        = g_we;
        end
    end

    // Response data: memory read data for a good load, zero otherwise.
    assign resp_data = (go && !g_we) ? mem_rd : '0;

    always_comb begin
        last_d    = last_q;
        rvalid0_d = gnt0;
        rvalid1_d = gnt1;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        if (gnt0) begin
            last_d   = 1'b0;
            rdata0_d = resp_data;
            err0_d   = fault;
        end
        if (gnt1) begin
            last_d   = 1'b1;
            rdata1_d = resp_data;
            err1_d   = fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    // Responses are masked while rst is high so a response falling in a
    // reset cycle is never seen; the registers clear at the same edge.
    assign r0.gnt    = gnt0;
    assign r1.gnt    = gnt1;
    assign r0.rvalid = rvalid0_q & ~rst;
    assign r1.rvalid = rvalid1_q & ~rst;
    assign r0.rdata  = rst ? '0 : rdata0_q;
    assign r1.rdata  = rst ? '0 : rdata1_q;
    assign r0.err    = err0_q & ~rst;
    assign r1.err    = err1_q & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_addr_mode;
    logic        mem_we;
    logic [31:0] mem_rd;

    int tests;
    int failed;

    dmem_arbiter_if #(.DATA_WIDTH(32)) r0_if ();
    dmem_arbiter_if #(.DATA_WIDTH(32)) r1_if ();

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_BITS(17)) dut (
        .clk           (clk),
        .rst           (rst),
        .r0            (r0_if),
        .r1            (r1_if),
        .mem_a         (mem_a),
        .mem_wd        (mem_wd),
        .mem_addr_mode (mem_addr_mode),
        .mem_we        (mem_we),
        .mem_rd        (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian byte memory model, combinational read, write at the edge.
    logic [7:0]  mem [0:131071];
    logic [16:0] ma;
    assign ma = mem_a[16:0];
    assign mem_rd = mem_addr_mode ? {24'h0, mem[ma]}
                                  : {mem[ma + 17'd3], mem[ma + 17'd2], mem[ma + 17'd1], mem[ma]};

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr_mode) begin
                mem[ma] <= mem_wd[7:0];
            end else begin
                mem[ma]         <= mem_wd[7:0];
                mem[ma + 17'd1] <= mem_wd[15:8];
                mem[ma + 17'd2] <= mem_wd[23:16];
                mem[ma + 17'd3] <= mem_wd[31:24];
            end
        end
    end

    task automatic set_r0(input logic req, input logic we, input logic mode,
                          input logic [31:0] addr, input logic [31:0] wdata);
        r0_if.req = req; r0_if.we = we; r0_if.addr_mode = mode;
        r0_if.addr = addr; r0_if.wdata = wdata;
    endtask

    task automatic set_r1(input logic req, input logic we, input logic mode,
                          input logic [31:0] addr, input logic [31:0] wdata);
        r1_if.req = req; r1_if.we = we; r1_if.addr_mode = mode;
        r1_if.addr = addr; r1_if.wdata = wdata;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (r0_if.rvalid !== 1'b0) begin failed++; $display("FAIL reset_r0_rvalid: got %0b want 0", r0_if.rvalid); end
        tests++; if (r0_if.rdata !== 32'h0) begin failed++; $display("FAIL reset_r0_rdata: got %h want 0", r0_if.rdata); end
        tests++; if (r0_if.err !== 1'b0) begin failed++; $display("FAIL reset_r0_err: got %0b want 0", r0_if.err); end
        tests++; if (r1_if.rvalid !== 1'b0) begin failed++; $display("FAIL reset_r1_rvalid: got %0b want 0", r1_if.rvalid); end
        tests++; if (mem_we !== 1'b0) begin failed++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
    endtask

    task automatic test_req_during_reset;
        @(negedge clk);
        set_r0(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (r0_if.gnt !== 1'b0) begin failed++; $display("FAIL rsthold_gnt%0d: got %0b want 0", i, r0_if.gnt); end
            tests++; if (mem_we !== 1'b0 || mem_a !== 32'h0) begin failed++; $display("FAIL rsthold_mem%0d: got we=%0b a=%h want 0/0", i, mem_we, mem_a); end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        tests++; if (r0_if.gnt !== 1'b1) begin failed++; $display("FAIL first_gnt: got %0b want 1", r0_if.gnt); end
        tests++; if (mem_a !== 32'h0001_0000 || mem_we !== 1'b0) begin failed++; $display("FAIL first_mem: got a=%h we=%0b want 00010000/0", mem_a, mem_we); end
        @(negedge clk);
        set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        tests++; if (r0_if.rvalid !== 1'b1) begin failed++; $display("FAIL first_rvalid: got %0b want 1", r0_if.rvalid); end
        tests++; if (r0_if.rdata !== 32'hDEAD_BEEF) begin failed++; $display("FAIL first_rdata: got %h want deadbeef", r0_if.rdata); end
        tests++; if (r0_if.err !== 1'b0) begin failed++; $display("FAIL first_err: got %0b want 0", r0_if.err); end
        tests++; if (r1_if.rvalid !== 1'b0) begin failed++; $display("FAIL first_r1_rvalid: got %0b want 0", r1_if.rvalid); end
        @(negedge clk);
        #1;
        tests++; if (r0_if.rvalid !== 1'b0) begin failed++; $display("FAIL pulse_len: got %0b want 0", r0_if.rvalid); end
        tests++; if (r0_if.rdata !== 32'hDEAD_BEEF) begin failed++; $display("FAIL rdata_hold: got %h want deadbeef", r0_if.rdata); end
    endtask

    task automatic test_contention;
        logic e0;
        logic e1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_r0(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0);
        set_r1(1'b1, 1'b0, 1'b0, 32'h0001_0004, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            e0 = (i % 2 == 0);
            e1 = (i % 2 == 1);
            tests++; if (r0_if.gnt !== e0 || r1_if.gnt !== e1) begin failed++; $display("FAIL rr_gnt%0d: got %0b%0b want %0b%0b", i, r0_if.gnt, r1_if.gnt, e0, e1); end
            if (i > 0) begin
                tests++; if (r0_if.rvalid !== e1 || r1_if.rvalid !== e0) begin failed++; $display("FAIL rr_rvalid%0d: got %0b%0b want %0b%0b", i, r0_if.rvalid, r1_if.rvalid, e1, e0); end
            end
            @(negedge clk);
        end
        set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_r1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        tests++; if (r1_if.rvalid !== 1'b1 || r0_if.rvalid !== 1'b0) begin failed++; $display("FAIL rr_last_rvalid: got r0=%0b r1=%0b want 0/1", r0_if.rvalid, r1_if.rvalid); end
        tests++; if (r1_if.rdata !== 32'h1234_5678) begin failed++; $display("FAIL rr_r1_rdata: got %h want 12345678", r1_if.rdata); end
        tests++; if (r0_if.rdata !== 32'hDEAD_BEEF) begin failed++; $display("FAIL rr_r0_rdata: got %h want deadbeef", r0_if.rdata); end
    endtask

    task automatic test_raw_byte;
        set_r1(1'b1, 1'b1, 1'b1, 32'h0001_0003, 32'h0000_00A5);
        #1;
        tests++; if (r1_if.gnt !== 1'b1 || r0_if.gnt !== 1'b0) begin failed++; $display("FAIL sb_gnt: got r0=%0b r1=%0b want 0/1", r0_if.gnt, r1_if.gnt); end
        tests++; if (mem_we !== 1'b1 || mem_a !== 32'h0001_0003 || mem_wd !== 32'hA5 || mem_addr_mode !== 1'b1) begin
            failed++; $display("FAIL sb_mem: got we=%0b a=%h wd=%h m=%0b want 1/00010003/000000a5/1", mem_we, mem_a, mem_wd, mem_addr_mode); end
        @(negedge clk);
        set_r1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_r0(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0);
        #1;
        tests++; if (r1_if.rvalid !== 1'b1 || r1_if.err !== 1'b0 || r1_if.rdata !== 32'h0) begin
            failed++; $display("FAIL sb_resp: got v=%0b e=%0b d=%h want 1/0/0", r1_if.rvalid, r1_if.err, r1_if.rdata); end
        tests++; if (r0_if.gnt !== 1'b1) begin failed++; $display("FAIL raw_gnt: got %0b want 1", r0_if.gnt); end
        @(negedge clk);
        set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        tests++; if (r0_if.rvalid !== 1'b1 || r0_if.rdata !== 32'hA5AD_BEEF) begin
            failed++; $display("FAIL raw_rdata: got v=%0b d=%h want 1/a5adbeef", r0_if.rvalid, r0_if.rdata); end
    endtask

    task automatic test_faults;
        set_r0(1'b1, 1'b0, 1'b0, 32'h0001_0002, 32'h0);
        #1;
        tests++; if (r0_if.gnt !== 1'b1 || mem_we !== 1'b0 || mem_a !== 32'h0) begin
            failed++; $display("FAIL mis_grant: got g=%0b we=%0b a=%h want 1/0/0", r0_if.gnt, mem_we, mem_a); end
        @(negedge clk);
        set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_r1(1'b1, 1'b1, 1'b0, 32'h0002_0000, 32'hFFFF_FFFF);
        #1;
        tests++; if (r1_if.gnt !== 1'b1 || mem_we !== 1'b0 || mem_wd !== 32'h0) begin
            failed++; $display("FAIL oor_grant: got g=%0b we=%0b wd=%h want 1/0/0", r1_if.gnt, mem_we, mem_wd); end
        tests++; if (r0_if.rvalid !== 1'b1 || r0_if.err !== 1'b1 || r0_if.rdata !== 32'h0) begin
            failed++; $display("FAIL mis_resp: got v=%0b e=%0b d=%h want 1/1/0", r0_if.rvalid, r0_if.err, r0_if.rdata); end
        @(negedge clk);
        set_r1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_r0(1'b1, 1'b0, 1'b1, 32'h0001_FFFF, 32'h0);
        #1;
        tests++; if (r1_if.rvalid !== 1'b1 || r1_if.err !== 1'b1 || r1_if.rdata !== 32'h0) begin
            failed++; $display("FAIL oor_resp: got v=%0b e=%0b d=%h want 1/1/0", r1_if.rvalid, r1_if.err, r1_if.rdata); end
        tests++; if (r0_if.gnt !== 1'b1 || mem_a !== 32'h0001_FFFF || mem_addr_mode !== 1'b1) begin
            failed++; $display("FAIL top_byte_mem: got g=%0b a=%h m=%0b want 1/0001ffff/1", r0_if.gnt, mem_a, mem_addr_mode); end
        @(negedge clk);
        set_r0(1'b1, 1'b0, 1'b1, 32'h0002_0000, 32'h0);
        #1;
        tests++; if (r0_if.rvalid !== 1'b1 || r0_if.err !== 1'b0 || r0_if.rdata !== 32'h77) begin
            failed++; $display("FAIL top_byte_resp: got v=%0b e=%0b d=%h want 1/0/00000077", r0_if.rvalid, r0_if.err, r0_if.rdata); end
        tests++; if (r0_if.gnt !== 1'b1 || mem_a !== 32'h0) begin
            failed++; $display("FAIL oor_byte_mem: got g=%0b a=%h want 1/0", r0_if.gnt, mem_a); end
        @(negedge clk);
        set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        tests++; if (r0_if.rvalid !== 1'b1 || r0_if.err !== 1'b1 || r0_if.rdata !== 32'h0) begin
            failed++; $display("FAIL oor_byte_resp: got v=%0b e=%0b d=%h want 1/1/0", r0_if.rvalid, r0_if.err, r0_if.rdata); end
        tests++; if ({mem[17'h10003], mem[17'h10002], mem[17'h10001], mem[17'h10000]} !== 32'hA5AD_BEEF) begin
            failed++; $display("FAIL mem_untouched: got %h want a5adbeef", {mem[17'h10003], mem[17'h10002], mem[17'h10001], mem[17'h10000]}); end
    endtask

    task automatic test_reset_cancel;
        @(negedge clk);
        set_r1(1'b1, 1'b0, 1'b0, 32'h0001_0004, 32'h0);
        #1;
        tests++; if (r1_if.gnt !== 1'b1) begin failed++; $display("FAIL cancel_gnt: got %0b want 1", r1_if.gnt); end
        @(negedge clk);
        rst = 1'b1;
        set_r1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        tests++; if (r1_if.rvalid !== 1'b0 || r1_if.rdata !== 32'h0 || r1_if.err !== 1'b0) begin
            failed++; $display("FAIL cancel_resp: got v=%0b d=%h e=%0b want 0/0/0", r1_if.rvalid, r1_if.rdata, r1_if.err); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (r1_if.rvalid !== 1'b0 || r1_if.rdata !== 32'h0 || r1_if.err !== 1'b0) begin
            failed++; $display("FAIL cancel_after: got v=%0b d=%h e=%0b want 0/0/0", r1_if.rvalid, r1_if.rdata, r1_if.err); end
        tests++; if (r0_if.err !== 1'b0 || r0_if.rvalid !== 1'b0) begin
            failed++; $display("FAIL cancel_r0: got e=%0b v=%0b want 0/0", r0_if.err, r0_if.rvalid); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        set_r0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_r1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        mem[17'h10000] = 8'hEF; mem[17'h10001] = 8'hBE;
        mem[17'h10002] = 8'hAD; mem[17'h10003] = 8'hDE;
        mem[17'h10004] = 8'h78; mem[17'h10005] = 8'h56;
        mem[17'h10006] = 8'h34; mem[17'h10007] = 8'h12;
        mem[17'h1FFFF] = 8'h77;

        test_reset;
        test_req_during_reset;
        test_contention;
        test_raw_byte;
        test_faults;
        test_reset_cancel;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-port, byte-addressed data memory. Shares the memory between requester 0 (pipeline load/store unit) and requester 1 (loader/debug port) with round-robin fairness and a valid/grant handshake. Per accepted request, it drives the memory's address, write-data, byte/word mode and write-enable for exactly one cycle. It returns a registered response (read data or write acknowledge, plus error) one cycle later. Faulting requests (misaligned word, out-of-range address) are rejected without touching memory.

## Interface
- DATA_WIDTH, 32: data and address width.
- ADDR_BITS, 17: implemented memory address bits. Valid range is 0 to 2^ADDR_BITS-1.
- clk  input  1  clock. All state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rN_req  input  1  requester N (N = 0, 1) request valid. Held with stable payload until granted.
- rN_we  input  1  1 = store, 0 = load.
- rN_addr_mode  input  1  0 = word, 1 = byte (load unsigned byte / store byte).
- rN_addr  input  DATA_WIDTH  byte address.
- rN_wdata  input  DATA_WIDTH  store data. Byte store uses [7:0].
- rN_gnt  output  1  request accepted this cycle (combinational).
- rN_rvalid  output  1  response valid (registered, one-cycle pulse).
- rN_rdata  output  DATA_WIDTH  load data. 0 for stores and errors.
- rN_err  output  1  response is a fault. Valid with rN_rvalid.
- mem_a  output  DATA_WIDTH  memory address.
- mem_wd  output  DATA_WIDTH  memory write data.
- mem_addr_mode  output  1  memory byte/word mode.
- mem_we  output  1  memory write enable.
- mem_rd  input  DATA_WIDTH  memory combinational read data.

## Operation
- Grant pointer `last` (1 bit) records the most recently granted requester. Reset value 1, so r0 wins the first contention.
- Arbitration, each cycle with rst low:
  - Only one rN_req high: grant it.
  - Both high: grant the requester not equal to `last`.
  - Neither high: no grant.
- `last` updates to the granted requester on every grant, including faulting ones.
- At most one rN_gnt high per cycle. Throughput is one access per cycle, and back-to-back grants are allowed.
- Fault check on the granted request:
  - Misaligned: addr_mode=0 and addr[1:0] != 0.
  - Out of range: addr[DATA_WIDTH-1:ADDR_BITS] != 0. A word access is also out of range if addr+3 exceeds 2^ADDR_BITS-1.
- Accepted non-fault request: mem_a/mem_wd/mem_addr_mode take the granted payload, and mem_we = rN_we. A store commits at the same rising edge. For a load, mem_rd is captured into rN_rdata at that edge.
- Faulting or absent request: mem_we = 0 and mem_a/mem_wd/mem_addr_mode = 0. Memory is never written.
- Response: the cycle after a grant, the granted requester sees rvalid = 1 for exactly one cycle.
  - err = fault flag.
  - rdata = captured mem_rd for a non-fault load, otherwise 0.
- The other requester's rvalid is 0. rdata/err hold their last value while rvalid = 0.

## Timing
- Reset values: rN_rvalid = 0, rN_rdata = 0, rN_err = 0, `last` = 1.
- While rst is high: rN_gnt = 0, mem_we = 0, mem_a/mem_wd/mem_addr_mode = 0.
- A request presented while rst is high is not accepted. It must remain held and is arbitrated normally in the first cycle with rst low.
- A response due in the cycle after a grant is cancelled if rst is high at that edge; rvalid stays 0.
- Latency: request visible at edge k with gnt high in cycle k; rvalid high in cycle k+1. Loads return data for the memory contents before any store committing at edge k+1.
- Read-after-write to the same address from either requester in consecutive grants returns the new data.
- Requesters sample gnt at the rising edge. A requester seeing gnt = 1 may present its next request in the following cycle.
- No combinational path from rN_req to rN_rvalid/rN_rdata.

## Test plan
- Reset, then r0 load word at 0x10000 containing 0xDEADBEEF.
  -> r0_gnt = 1 in cycle 0; mem_a = 0x10000, mem_we = 0.
  -> cycle 1: r0_rvalid = 1, r0_rdata = 0xDEADBEEF, r0_err = 0.
- Both requesters hold loads for 4 cycles.
  -> grants alternate r0, r1, r0, r1, and each rvalid follows its grant by one cycle.
- r1 store byte 0xA5 to 0x10003, then r0 load word at 0x10000 in the next cycle.
  -> r0_rdata[31:24] = 0xA5, other bytes unchanged.
- r0 load word at 0x10002, then r1 store word at 0x00020000.
  -> each: gnt = 1, mem_we = 0, rvalid with err = 1 and rdata = 0; memory unchanged.
- r0 requesting while rst is high for 3 cycles.
  -> no gnt, mem_we = 0; gnt in the first cycle after rst drops.
- rst asserted in the cycle after an r1 grant.
  -> r1_rvalid stays 0, rdata/err = 0.
